// File: rtl/ext_wb_pkg.sv
// ext_wb_pkg: shared types and constants for the ext-to-Wishbone master bridge.
package ext_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/ext_wb_timeout.sv
// ext_wb_timeout: loadable up-counter with clear/enable and terminal count.
// TIMEOUT_CYCLES == 0 disables the terminal-count output.
module ext_wb_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign tc_o = 1'b0;
  end else begin : g_on
    assign tc_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/ext_wb_master.sv
// ext_wb_master: core ext request port to Wishbone B4 classic master, with bus timeout.
// Optional sticky error status outputs under EXT_WB_ERR_STATUS_EN.
module ext_wb_master
  import ext_wb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ext_valid,
  output logic                        ext_ready,
  input  logic [ADDR_W-1:0]           ext_address,
  input  logic [DATA_W-1:0]           ext_write_data,
  input  logic [strb_w(DATA_W)-1:0]   ext_write_strobe,
  input  logic                        ext_instruction,
  output logic [DATA_W-1:0]           ext_read_data,
  output logic                        wbm_cyc_o,
  output logic                        wbm_stb_o,
  output logic                        wbm_we_o,
  output logic [ADDR_W-1:0]           wbm_adr_o,
  output logic [DATA_W-1:0]           wbm_dat_o,
  output logic [strb_w(DATA_W)-1:0]   wbm_sel_o,
  output logic                        wbm_tgc_o,
  input  logic [DATA_W-1:0]           wbm_dat_i,
  input  logic                        wbm_ack_i,
  input  logic                        wbm_err_i
`ifdef EXT_WB_ERR_STATUS_EN
  ,
  output logic                        bus_error,
  output logic [ADDR_W-1:0]           err_address
`endif
);

  localparam int SW = strb_w(DATA_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic              we_q, we_d;
  logic              tgc_q, tgc_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              tc;
  logic              accept;

  assign accept = (state_q == IDLE) && ext_valid;

  ext_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (state_q == RESP),
    .en_i      (state_q == BUS),
    .load_i    (accept),
    .load_val_i('0),
    .tc_o      (tc)
  );

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    tgc_d   = tgc_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (ext_valid) begin
          state_d = BUS;
          adr_d   = {ext_address[ADDR_W-1:2], 2'b00};
          dat_d   = ext_write_data;
          we_d    = |ext_write_strobe;
          sel_d   = we_d ? ext_write_strobe : '1;
          tgc_d   = ext_instruction;
        end
      end
      BUS: begin
        // ack has priority over a simultaneous err
        if (wbm_ack_i) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : wbm_dat_i;
        end else if (wbm_err_i || tc) begin
          state_d = RESP;
          rdata_d = we_q ? '0 : ERR_DATA;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      tgc_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      tgc_q   <= tgc_d;
      rdata_q <= rdata_d;
    end
  end

  assign wbm_cyc_o     = (state_q == BUS);
  assign wbm_stb_o     = (state_q == BUS);
  assign wbm_we_o      = we_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_tgc_o     = tgc_q;
  assign ext_ready     = (state_q == RESP);
  assign ext_read_data = rdata_q;

`ifdef EXT_WB_ERR_STATUS_EN
  logic              bus_error_q, bus_error_d;
  logic [ADDR_W-1:0] err_adr_q, err_adr_d;

  always_comb begin
    bus_error_d = bus_error_q;
    err_adr_d   = err_adr_q;
    if (state_q == BUS && !wbm_ack_i && (wbm_err_i || tc)) begin
      bus_error_d = 1'b1;
      if (!bus_error_q) err_adr_d = adr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_error_q <= 1'b0;
      err_adr_q   <= '0;
    end else begin
      bus_error_q <= bus_error_d;
      err_adr_q   <= err_adr_d;
    end
  end

  assign bus_error   = bus_error_q;
  assign err_address = err_adr_q;
`else
  // error completions are only visible through ERR_DATA
`endif

endmodule
